phys_reg_free_list: RTL and testbench
=====================================

// Module: phys_reg_free_list
// PURPOSE
// - Circular free list of physical register IDs feeding the in-use toggle-memory set.
// - Hands one free ID per cycle to issue/rename (alloc port).
//   Accepts up to NUM_RELEASE_PORTS retired IDs per cycle back from writeback/commit.
// - Owns post-reset init: fills itself with IDs NUM_ARCH..DEPTH-1 and drives init_clear
//   to the toggle-memory set for exactly DEPTH cycles.
// - Mirrors every alloc/release as a toggle request so the set tracks ownership.
// PARAMETERS
// - DEPTH             64  total physical registers; power of two, >= 4
// - NUM_ARCH          32  IDs 0..NUM_ARCH-1 are mapped at reset, never initially free; < DEPTH
// - NUM_RELEASE_PORTS 2   release ports per cycle; 1..4
// PORTS
// - clk           in  1                 clock, rising edge
// - rst           in  1                 asynchronous, active-low reset
// - init_clear    out 1                 high while clearing the toggle-memory set
// - alloc_req     in  1                 issue requests an ID this cycle
// - alloc_valid   out 1                 a free ID is presented
// - alloc_id      out log2(DEPTH)       presented free ID
// - release       in  [NUM_RELEASE_PORTS] x 1            return ID on port p
// - release_id    in  [NUM_RELEASE_PORTS] x log2(DEPTH)  returned IDs
// - toggle        out [NUM_RELEASE_PORTS+1] x 1             toggle strobes to set
// - toggle_addr   out [NUM_RELEASE_PORTS+1] x log2(DEPTH)   toggle addresses to set
// - free_count    out log2(DEPTH)+1     current number of free IDs
// BEHAVIOUR
// - FREE = DEPTH-NUM_ARCH. Storage: DEPTH x log2(DEPTH) register array.
//   head/tail pointers log2(DEPTH) bits, natural wrap at DEPTH.
// - Reset (rst low, async) values: init_clear=1, alloc_valid=0, free_count=0,
//   head=tail=0, init counter=0, toggles=0.
// - States: INIT -> RUN.
//   - INIT: counter k = 0..DEPTH-1, one step per cycle after rst rises.
//     When k<FREE, write mem[k]=NUM_ARCH+k.
//     init_clear=1 for exactly DEPTH cycles, then 0.
//   - At INIT->RUN: tail=FREE mod DEPTH, free_count=FREE.
//   - rst assertion in any state returns to INIT at k=0 and discards all contents.
// - Alloc:
//   - alloc_valid = RUN & (free_count!=0).
//   - alloc_id = mem[head], combinational from registered head, zero added latency.
//   - fire = alloc_req & alloc_valid: head+1 next cycle, free_count-1.
//   - alloc_req while !alloc_valid: ignored, no state change.
// - Release:
//   - Ports are packed in port order at tail: port p writes mem[tail+n_p], where n_p is the
//     count of asserted lower ports.
//   - tail += popcount(release); free_count += popcount.
//   - Visible to alloc from the next cycle; no same-cycle bypass. Releases with free_count=0
//     leave alloc_valid low that cycle.
// - Simultaneous alloc fire + N releases: free_count += N-1; head and tail update independently.
// - Toggles:
//   - toggle[0] = alloc fire, toggle_addr[0] = alloc_id.
//   - toggle[1+p] = release[p] & RUN, toggle_addr[1+p] = release_id[p].
//   - All combinational, same cycle as the event.
// - Illegal (assert, no defined behaviour):
//   - release during INIT;
//   - free_count+popcount(release) > FREE;
//   - same ID released twice in one cycle.
// - free_count never exceeds FREE; head==tail with free_count=0 means empty.
//   Full never reaches DEPTH entries, so no full/empty ambiguity.
// STRUCTURE
// - phys_id_t (logic [$clog2(DEPTH)-1:0]) and FREE derivation go in the shared core
//   types package, reused by the rename table and toggle-memory-set instantiation.
// - No sub-module. Single file: init counter, pointers, count, storage, popcount/pack logic.
// - Top-level wiring: init_clear -> set.init_clear; toggle/toggle_addr -> set.toggle/toggle_addr.
//   Set NUM_WRITE_PORTS = NUM_RELEASE_PORTS+1.
// TESTING
// - Reset, idle DEPTH+2 cycles:
//   - init_clear high exactly 64 cycles after rst rises;
//   - then alloc_valid=1, free_count=32, alloc_id=32.
// - alloc_req held 32 cycles:
//   - IDs 32..63 in order, one per cycle, toggle[0] each cycle;
//   - then alloc_valid=0, free_count=0.
// - From empty, release[0]=5, release[1]=9 same cycle:
//   - next cycle free_count=2, alloc_id=5;
//   - after one fire alloc_id=9.
// - Steady state, alloc fire + release[1]=40 (port 0 idle) each cycle for 200 cycles:
//   - free_count constant; pointer wrap past 63 correct;
//   - released IDs reappear in FIFO order.
// - rst pulsed low mid-run with free_count=7:
//   - outputs immediately reset values, init repeats;
//   - list again 32..63, free_count=32.
// - Random alloc/release vs. reference set model over 10k cycles:
//   - no ID allocated twice while held;
//   - toggle stream keeps set in_use == model ownership.

Source files
------------

// File: rtl/phys_reg_free_list_pkg.sv
// Shared core types for the physical register file: ID type, default sizing
// and the free-pool derivation used by the free list and rename logic.
package phys_reg_free_list_pkg;

    localparam int DEFAULT_DEPTH             = 64;
    localparam int DEFAULT_NUM_ARCH          = 32;
    localparam int DEFAULT_NUM_RELEASE_PORTS = 2;
    localparam int PHYS_ID_W                 = $clog2(DEFAULT_DEPTH);

    typedef logic [PHYS_ID_W-1:0] phys_id_t;

    typedef enum logic {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_state_e;

    // IDs that are not architecturally mapped at reset form the initial free pool.
    function automatic int free_entries(input int depth, input int num_arch);
        return depth - num_arch;
    endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register IDs: one allocation per cycle, several
// in-order packed releases per cycle, and a mirrored toggle stream for the in-use set.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
#(
    parameter int DEPTH             = DEFAULT_DEPTH,
    parameter int NUM_ARCH          = DEFAULT_NUM_ARCH,
    parameter int NUM_RELEASE_PORTS = DEFAULT_NUM_RELEASE_PORTS
) (
    input  logic                                             clk,
    input  logic                                             rst,
    output logic                                             init_clear,
    input  logic                                             alloc_req,
    output logic                                             alloc_valid,
    output logic [$clog2(DEPTH)-1:0]                         alloc_id,
    input  logic [NUM_RELEASE_PORTS-1:0]                     release_req,
    input  logic [NUM_RELEASE_PORTS-1:0][$clog2(DEPTH)-1:0]  release_id,
    output logic [NUM_RELEASE_PORTS:0]                       toggle,
    output logic [NUM_RELEASE_PORTS:0][$clog2(DEPTH)-1:0]    toggle_addr,
    output logic [$clog2(DEPTH):0]                           free_count
);

    localparam int ID_W  = $clog2(DEPTH);
    localparam int CNT_W = ID_W + 1;
    localparam int FREE  = free_entries(DEPTH, NUM_ARCH);

    fl_state_e                                state_reg, state_next;
    logic [ID_W-1:0]                          init_k_reg;
    logic [ID_W-1:0]                          head_reg, tail_reg;
    logic [CNT_W-1:0]                         free_count_reg;
    logic [ID_W-1:0]                          mem [DEPTH];

    logic                                     run;
    logic                                     fire;
    logic                                     init_done;
    logic [NUM_RELEASE_PORTS-1:0]             rel_eff;
    logic [NUM_RELEASE_PORTS-1:0][ID_W-1:0]   rel_off;
    logic [CNT_W-1:0]                         rel_count;
    logic                                     rel_dup;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= FL_INIT;
        else      state_reg <= state_next;
    end

    assign init_done = (state_reg == FL_INIT) && (init_k_reg == ID_W'(DEPTH - 1));

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (init_done) state_next = FL_RUN;
    end

    // Output logic
    always_comb begin
        run         = (state_reg == FL_RUN);
        init_clear  = (state_reg == FL_INIT);
        alloc_valid = run && (free_count_reg != '0);
    end

    assign alloc_id   = mem[head_reg];
    assign fire       = alloc_req && alloc_valid;
    assign free_count = free_count_reg;
    assign rel_eff    = release_req & {NUM_RELEASE_PORTS{run}};

    // Each asserted port lands after all asserted lower-numbered ports.
    always_comb begin
        rel_count = '0;
        rel_off   = '0;
        for (int p = 0; p < NUM_RELEASE_PORTS; p++) begin
            rel_off[p] = rel_count[ID_W-1:0];
            if (rel_eff[p]) rel_count = rel_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_k_reg     <= '0;
            head_reg       <= '0;
            tail_reg       <= '0;
            free_count_reg <= '0;
        end else if (state_reg == FL_INIT) begin
            init_k_reg <= init_k_reg + ID_W'(1);
            if (init_done) begin
                tail_reg       <= ID_W'(FREE % DEPTH);
                free_count_reg <= CNT_W'(FREE);
            end
        end else begin
            head_reg       <= head_reg + ID_W'(fire);
            tail_reg       <= tail_reg + rel_count[ID_W-1:0];
            free_count_reg <= free_count_reg + rel_count - CNT_W'(fire);
        end
    end

    // Storage has no reset: init rewrites every entry that can be read before a release fills it.
    always_ff @(posedge clk) begin
        if (state_reg == FL_INIT) begin
            if ({1'b0, init_k_reg} < CNT_W'(FREE))
                mem[init_k_reg] <= ID_W'(NUM_ARCH) + init_k_reg;
        end else begin
            for (int p = 0; p < NUM_RELEASE_PORTS; p++) begin
                if (rel_eff[p]) mem[tail_reg + rel_off[p]] <= release_id[p];
            end
        end
    end

    assign toggle[0]      = fire;
    assign toggle_addr[0] = alloc_id;

    generate
        for (genvar gi = 0; gi < NUM_RELEASE_PORTS; gi++) begin : g_rel_toggle
            assign toggle[gi+1]      = rel_eff[gi];
            assign toggle_addr[gi+1] = release_id[gi];
        end
    endgenerate

    always_comb begin
        rel_dup = 1'b0;
        for (int i = 0; i < NUM_RELEASE_PORTS; i++)
            for (int j = i + 1; j < NUM_RELEASE_PORTS; j++)
                if (release_req[i] && release_req[j] && (release_id[i] == release_id[j]))
                    rel_dup = 1'b1;
    end

    a_no_release_in_init: assert property (@(posedge clk) disable iff (!rst)
        !((state_reg == FL_INIT) && (|release_req)));
    a_no_overfill: assert property (@(posedge clk) disable iff (!rst)
        (({1'b0, free_count_reg} + {1'b0, rel_count}) <= (CNT_W+1)'(FREE)));
    a_no_dup_release: assert property (@(posedge clk) disable iff (!rst) !rel_dup);

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: expected alloc IDs are queued as they
// enter the list (init fill, releases) and popped when an allocation fires.
module tb_phys_reg_free_list;
    import phys_reg_free_list_pkg::*;

    localparam int DEPTH    = 64;
    localparam int NUM_ARCH = 32;
    localparam int NRP      = 2;
    localparam int W        = 6;
    localparam int FREE     = DEPTH - NUM_ARCH;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    init_clear;
    logic                    alloc_req;
    logic                    alloc_valid;
    phys_id_t                alloc_id;
    logic [NRP-1:0]          release_req;
    logic [NRP-1:0][W-1:0]   release_id;
    logic [NRP:0]            toggle;
    logic [NRP:0][W-1:0]     toggle_addr;
    logic [W:0]              free_count;

    always #5 clk = ~clk;

    phys_reg_free_list #(
        .DEPTH(DEPTH), .NUM_ARCH(NUM_ARCH), .NUM_RELEASE_PORTS(NRP)
    ) dut (
        .clk(clk), .rst(rst), .init_clear(init_clear),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_id(alloc_id),
        .release_req(release_req), .release_id(release_id),
        .toggle(toggle), .toggle_addr(toggle_addr), .free_count(free_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] held[$];
    int          model_count = 0;
    bit          model_run = 1'b0;
    bit          owned [DEPTH];
    bit          in_use [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_init_clear"}, init_clear, 1);
        chk({tag, "_alloc_valid"}, alloc_valid, 0);
        chk({tag, "_free_count"}, free_count, 0);
        chk({tag, "_toggle"}, toggle, 0);
    endtask

    // Releases rst at a falling edge, measures the init_clear window, then loads the model.
    task automatic wait_init();
        int n;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n = 0;
        while (init_clear === 1'b1 && n < DEPTH + 10) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("init_len", n, DEPTH);
        model_run   = 1'b1;
        model_count = FREE;
        sb.delete();
        held.delete();
        for (int i = 0; i < FREE; i++) sb.push_back(W'(NUM_ARCH + i));
        for (int i = 0; i < DEPTH; i++) begin
            owned[i]  = 1'b0;
            in_use[i] = 1'b0;
        end
    endtask

    task automatic do_cycle(input bit areq, input bit [NRP-1:0] rel,
                            input logic [W-1:0] id0, input logic [W-1:0] id1);
        logic [W-1:0] ids [NRP];
        logic [W-1:0] exp_id;
        logic [NRP:0] exp_tog;
        bit           fire;
        ids[0] = id0;
        ids[1] = id1;
        @(negedge clk);
        alloc_req   = areq;
        release_req = rel;
        release_id[0] = id0;
        release_id[1] = id1;
        #1;
        fire = areq && model_run && (model_count != 0);
        chk("alloc_valid", alloc_valid, model_run && (model_count != 0));
        chk("free_count", free_count, model_count);
        chk("init_clear", init_clear, !model_run);
        exp_tog = {rel & {NRP{model_run}}, fire};
        chk("toggle", toggle, exp_tog);
        if (model_run && model_count != 0) begin
            exp_id = sb[0];
            chk("alloc_id", alloc_id, exp_id);
        end
        if (fire) begin
            exp_id = sb.pop_front();
            chk("alloc_not_held", owned[alloc_id], 0);
            chk("toggle_addr0", toggle_addr[0], exp_id);
            owned[exp_id] = 1'b1;
            held.push_back(exp_id);
            model_count--;
        end
        for (int p = 0; p < NRP; p++) begin
            if (rel[p] && model_run) begin
                chk($sformatf("toggle_addr%0d", p + 1), toggle_addr[p+1], ids[p]);
                sb.push_back(ids[p]);
                owned[ids[p]] = 1'b0;
                model_count++;
            end
        end
        for (int i = 0; i <= NRP; i++)
            if (toggle[i] === 1'b1) in_use[toggle_addr[i]] = ~in_use[toggle_addr[i]];
        $display("cyc areq=%0b rel=%b id0=%0d id1=%0d valid=%0b alloc_id=%0d cnt=%0d",
                 areq, rel, id0, id1, alloc_valid, alloc_id, free_count);
    endtask

    initial begin
        bit [NRP-1:0] rel;
        logic [W-1:0] ids [NRP];
        bit           areq;
        int           idx;

        alloc_req   = 1'b0;
        release_req = '0;
        release_id  = '0;

        // Power-on reset and init window
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        wait_init();
        repeat (2) do_cycle(0, 2'b00, 0, 0);

        // Drain the whole list, then a request on an empty list is ignored
        repeat (FREE) do_cycle(1, 2'b00, 0, 0);
        do_cycle(1, 2'b00, 0, 0);
        do_cycle(0, 2'b00, 0, 0);

        // Two releases into an empty list come out in port order
        do_cycle(0, 2'b11, 6'd5, 6'd9);
        do_cycle(1, 2'b00, 0, 0);
        do_cycle(0, 2'b00, 0, 0);

        // Steady state across several pointer wraps
        repeat (200) do_cycle(1, 2'b10, 0, 6'd40);

        // Build up to seven free entries, then reset mid-run
        do_cycle(0, 2'b11, 6'd1, 6'd2);
        do_cycle(0, 2'b11, 6'd3, 6'd4);
        do_cycle(0, 2'b01, 6'd6, 0);
        do_cycle(0, 2'b01, 6'd7, 0);
        @(negedge clk);
        alloc_req   = 1'b0;
        release_req = '0;
        #1;
        chk("pre_rst_count", free_count, 7);
        #2;
        rst = 1'b0;
        model_run = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(negedge clk);
        #1;
        check_reset_outputs("midrun_hold");
        wait_init();
        repeat (FREE) do_cycle(1, 2'b00, 0, 0);

        // Random traffic; releases only return IDs currently held
        for (int cyc = 0; cyc < 10000; cyc++) begin
            areq = ($urandom_range(0, 2) != 0);
            rel  = '0;
            for (int p = 0; p < NRP; p++) begin
                ids[p] = '0;
                if (held.size() > 0 && $urandom_range(0, 2) == 0) begin
                    idx    = $urandom_range(0, held.size() - 1);
                    ids[p] = held[idx];
                    held.delete(idx);
                    rel[p] = 1'b1;
                end
            end
            do_cycle(areq, rel, ids[0], ids[1]);
        end
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("in_use_%0d", i), in_use[i], owned[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
